dlx_pipe_if: RTL and testbench

//  DLX instruction-fetch pipe stage; upstream producer of the IF/ID register consumed by decode.

---
 rtl/dlx_global_pkg.sv | 22 ++
 rtl/dlx_pipe_if.sv | 182 ++++++++++++++++++
 tb/tb_dlx_pipe_if.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dlx_global_pkg.sv
// Shared DLX types and constants.
// Instruction word, NOP encoding and fetch-stage FSM states.
package dlx_global_pkg;

  typedef logic [31:0] dlx_word;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] SP_NOP     = 6'h00;

  localparam dlx_word NOP_INSTR = {OP_SPECIAL, 20'h0_0000, SP_NOP};

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    HALTED   = 2'd2
  } if_state_t;

  function automatic dlx_word pc_inc(input dlx_word pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/dlx_pipe_if.sv
// DLX instruction-fetch stage: owns the PC, fetches over req/ack,
// feeds IF/ID and applies decode redirects, stalls and halt.
import dlx_global_pkg::*;

module dlx_pipe_if #(
  parameter dlx_word RESET_PC    = 32'h0000_0000,
  parameter dlx_word TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        dc_wait,
  input  logic        id_cond,
  input  logic [31:0] id_npc,
  input  logic        id_illegal_instr,
  input  logic        id_halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] if_id_npc,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_iar,
  output logic        if_halted
);

  if_state_t state, state_n;

  dlx_word fetch_pc, fetch_pc_n;
  dlx_word redir_pc, redir_pc_n;
  dlx_word ibuf, ibuf_n;
  dlx_word ir, ir_n;
  dlx_word npc, npc_n;
  dlx_word iar, iar_n;

  logic squash, squash_n;
  logic buf_valid, buf_valid_n;
  logic req_q, req_n;

  logic    hold;
  logic    ack;
  logic    take_halt;
  logic    take_ill;
  logic    take_cond;
  logic    redir;
  dlx_word target;

  assign hold = stall | dc_wait;
  assign ack  = imem_ack & req_q;

  // Decode redirects count only when the pipe is moving.
  assign take_halt = ~hold & id_halt;
  assign take_ill  = ~hold & ~id_halt & id_illegal_instr;
  assign take_cond = ~hold & ~id_halt & ~id_illegal_instr & id_cond;
  assign redir     = take_ill | take_cond;

  always_comb begin
    target = id_npc & ~32'd3;
    unique case (1'b1)
      take_ill: target = TRAP_VECTOR;
      default:  target = id_npc & ~32'd3;
    endcase
  end

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    redir_pc_n  = redir_pc;
    ibuf_n      = ibuf;
    ir_n        = ir;
    npc_n       = npc;
    iar_n       = iar;
    squash_n    = squash;
    buf_valid_n = buf_valid;
    req_n       = req_q;

    unique case (state)
      FETCH: begin
        req_n = 1'b1;
        if (take_halt) begin
          ir_n        = NOP_INSTR;
          buf_valid_n = 1'b0;
          squash_n    = 1'b0;
          state_n     = HALTED;
          // An unacked access must still complete.
          req_n       = req_q & ~ack;
        end else if (redir) begin
          ir_n        = NOP_INSTR;
          buf_valid_n = 1'b0;
          if (take_ill) iar_n = npc - 32'd4;
          if (!req_q || ack) begin
            fetch_pc_n = target;
            squash_n   = 1'b0;
          end else begin
            squash_n   = 1'b1;
            redir_pc_n = target;
          end
        end else if (ack) begin
          if (squash) begin
            squash_n   = 1'b0;
            fetch_pc_n = redir_pc;
          end else if (hold) begin
            ibuf_n      = imem_rdata;
            buf_valid_n = 1'b1;
            state_n     = BUFFERED;
            req_n       = 1'b0;
          end else begin
            ir_n       = imem_rdata;
            npc_n      = pc_inc(fetch_pc);
            fetch_pc_n = pc_inc(fetch_pc);
          end
        end
      end

      BUFFERED: begin
        req_n = 1'b0;
        if (take_halt) begin
          ir_n        = NOP_INSTR;
          buf_valid_n = 1'b0;
          state_n     = HALTED;
        end else if (redir) begin
          ir_n        = NOP_INSTR;
          buf_valid_n = 1'b0;
          if (take_ill) iar_n = npc - 32'd4;
          fetch_pc_n  = target;
          state_n     = FETCH;
          req_n       = 1'b1;
        end else if (!hold && buf_valid) begin
          ir_n        = ibuf;
          npc_n       = pc_inc(fetch_pc);
          fetch_pc_n  = pc_inc(fetch_pc);
          buf_valid_n = 1'b0;
          state_n     = FETCH;
          req_n       = 1'b1;
        end
      end

      HALTED: begin
        req_n = req_q & ~imem_ack;
      end

      default: begin
        state_n = FETCH;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      redir_pc  <= RESET_PC;
      ibuf      <= NOP_INSTR;
      ir        <= NOP_INSTR;
      npc       <= RESET_PC;
      iar       <= '0;
      squash    <= 1'b0;
      buf_valid <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      redir_pc  <= redir_pc_n;
      ibuf      <= ibuf_n;
      ir        <= ir_n;
      npc       <= npc_n;
      iar       <= iar_n;
      squash    <= squash_n;
      buf_valid <= buf_valid_n;
      req_q     <= req_n;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc;
  assign if_id_ir  = ir;
  assign if_id_npc = npc;
  assign if_iar    = iar;
  assign if_halted = (state == HALTED);

endmodule

// File: tb/tb_dlx_pipe_if.sv
// Bench for dlx_pipe_if: directed scenarios plus a randomized run
// checked against a program-order fetch model.
module tb_dlx_pipe_if;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        dc_wait = 1'b0;
  logic        id_cond = 1'b0;
  logic [31:0] id_npc = '0;
  logic        id_illegal_instr = 1'b0;
  logic        id_halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] if_id_npc;
  logic [31:0] if_id_ir;
  logic [31:0] if_iar;
  logic        if_halted;

  int checks = 0;
  int failures = 0;

  int fixed_lat = 0;
  int max_lat = 3;
  int wait_left = -1;
  logic [31:0] req_addr = '0;

  dlx_pipe_if dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .dc_wait(dc_wait),
    .id_cond(id_cond),
    .id_npc(id_npc),
    .id_illegal_instr(id_illegal_instr),
    .id_halt(id_halt),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ack(imem_ack),
    .if_id_npc(if_id_npc),
    .if_id_ir(if_id_ir),
    .if_iar(if_iar),
    .if_halted(if_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0020 + (a >> 2);
  endfunction

  // Memory: latency chosen per request, address must hold until ack.
  always @(negedge clk) begin
    if (!rst_n || imem_req !== 1'b1) begin
      imem_ack = 1'b0;
      wait_left = -1;
    end else begin
      if (wait_left < 0) begin
        if (fixed_lat >= 0) wait_left = fixed_lat;
        else wait_left = int'($urandom_range(0, max_lat));
        req_addr = imem_addr;
      end else begin
        checks++;
        if (imem_addr !== req_addr) begin
          failures++;
          $display("FAIL addr_stable: addr=%h held=%h", imem_addr, req_addr);
        end
      end
      if (wait_left == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem(imem_addr);
        wait_left = -1;
      end else begin
        imem_ack = 1'b0;
        wait_left--;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_npc(input logic [31:0] e, input int budget,
                          output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if (if_id_npc === e) hit = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fixed_lat = 0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || if_halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: req=%b halted=%b want 0 0", imem_req, if_halted);
    end
    checks++;
    if (if_id_ir !== NOP || if_id_npc !== 32'h0 || if_iar !== 32'h0
        || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: ir=%h npc=%h iar=%h addr=%h want all 0",
               if_id_ir, if_id_npc, if_iar, imem_addr);
    end
  endtask

  task automatic test_seq();
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL seq_req0: req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    step();
    checks++;
    if (if_id_ir !== 32'h1000_0020 || if_id_npc !== 32'h4 || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL seq_1: ir=%h npc=%h addr=%h want 10000020 4 4",
               if_id_ir, if_id_npc, imem_addr);
    end
    step();
    checks++;
    if (if_id_ir !== 32'h1000_0021 || if_id_npc !== 32'h8 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL seq_2: ir=%h npc=%h addr=%h want 10000021 8 8",
               if_id_ir, if_id_npc, imem_addr);
    end
  endtask

  task automatic test_redirect();
    id_cond = 1'b1;
    id_npc = 32'h40;
    step();
    id_cond = 1'b0;
    checks++;
    if (if_id_ir !== NOP || imem_addr !== 32'h40 || if_id_npc !== 32'h8) begin
      failures++;
      $display("FAIL redir_flush: ir=%h addr=%h npc=%h want 0 40 8",
               if_id_ir, imem_addr, if_id_npc);
    end
    step();
    checks++;
    if (if_id_ir !== mem(32'h40) || if_id_npc !== 32'h44) begin
      failures++;
      $display("FAIL redir_fetch: ir=%h npc=%h want %h 44",
               if_id_ir, if_id_npc, mem(32'h40));
    end
  endtask

  task automatic test_squash();
    bit hit;
    fixed_lat = 3;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h48) begin
      failures++;
      $display("FAIL squash_start: req=%b addr=%h want 1 48", imem_req, imem_addr);
    end
    id_cond = 1'b1;
    id_npc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      id_cond = 1'b0;
      checks++;
      if (imem_addr !== 32'h48 || imem_req !== 1'b1 || if_id_ir !== NOP) begin
        failures++;
        $display("FAIL squash_hold%0d: addr=%h req=%b ir=%h want 48 1 0",
                 i, imem_addr, imem_req, if_id_ir);
      end
    end
    step();
    checks++;
    if (imem_addr !== 32'h80 || if_id_ir !== NOP || if_id_npc !== 32'h48) begin
      failures++;
      $display("FAIL squash_drop: addr=%h ir=%h npc=%h want 80 0 48",
               imem_addr, if_id_ir, if_id_npc);
    end
    fixed_lat = 0;
    wait_npc(32'h84, 10, hit);
    checks++;
    if (!hit || if_id_ir !== mem(32'h80)) begin
      failures++;
      $display("FAIL squash_target: hit=%b ir=%h want 1 %h", hit, if_id_ir, mem(32'h80));
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b0 || if_id_ir !== mem(32'h80) || if_id_npc !== 32'h84) begin
        failures++;
        $display("FAIL stall_hold%0d: req=%b ir=%h npc=%h want 0 %h 84",
                 i, imem_req, if_id_ir, if_id_npc, mem(32'h80));
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (if_id_ir !== mem(32'h84) || if_id_npc !== 32'h88 || imem_addr !== 32'h88
        || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: ir=%h npc=%h addr=%h req=%b want %h 88 88 1",
               if_id_ir, if_id_npc, imem_addr, imem_req, mem(32'h84));
    end
  endtask

  task automatic test_illegal();
    id_cond = 1'b1;
    id_npc = 32'h20;
    step();
    id_cond = 1'b0;
    step();
    checks++;
    if (if_id_npc !== 32'h24 || if_id_ir !== mem(32'h20)) begin
      failures++;
      $display("FAIL ill_setup: npc=%h ir=%h want 24 %h", if_id_npc, if_id_ir, mem(32'h20));
    end
    id_illegal_instr = 1'b1;
    id_cond = 1'b1;
    id_npc = 32'h600;
    step();
    id_illegal_instr = 1'b0;
    id_cond = 1'b0;
    checks++;
    if (if_iar !== 32'h20 || imem_addr !== TRAP || if_id_ir !== NOP) begin
      failures++;
      $display("FAIL ill_trap: iar=%h addr=%h ir=%h want 20 100 0",
               if_iar, imem_addr, if_id_ir);
    end
    step();
    checks++;
    if (if_id_ir !== mem(TRAP) || if_id_npc !== 32'h104) begin
      failures++;
      $display("FAIL ill_vector: ir=%h npc=%h want %h 104", if_id_ir, if_id_npc, mem(TRAP));
    end
  endtask

  task automatic test_halt();
    bit hit;
    bit dropped;
    id_halt = 1'b1;
    id_cond = 1'b1;
    id_npc = 32'h300;
    step();
    id_halt = 1'b0;
    checks++;
    if (if_halted !== 1'b1 || imem_req !== 1'b0 || if_id_ir !== NOP) begin
      failures++;
      $display("FAIL halt_enter: halted=%b req=%b ir=%h want 1 0 0",
               if_halted, imem_req, if_id_ir);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h104) begin
        failures++;
        $display("FAIL halt_stay%0d: halted=%b req=%b addr=%h want 1 0 104",
                 i, if_halted, imem_req, imem_addr);
      end
    end
    id_cond = 1'b0;
    fixed_lat = 3;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || if_halted !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_abort: req=%b halted=%b addr=%h want 0 0 0",
               imem_req, if_halted, imem_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_refetch: req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    id_halt = 1'b1;
    step();
    id_halt = 1'b0;
    checks++;
    if (if_halted !== 1'b1 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL halt_pending: halted=%b req=%b want 1 1", if_halted, imem_req);
    end
    dropped = 1'b0;
    for (int i = 0; i < 6 && !dropped; i++) begin
      step();
      if (imem_req === 1'b0) dropped = 1'b1;
    end
    checks++;
    if (!dropped || if_id_ir !== NOP) begin
      failures++;
      $display("FAIL halt_ack: req_dropped=%b ir=%h want 1 0", dropped, if_id_ir);
    end
    fixed_lat = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_npc(32'h4, 8, hit);
    checks++;
    if (!hit || if_id_ir !== mem(32'h0) || if_halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_exit: hit=%b ir=%h halted=%b want 1 %h 0",
               hit, if_id_ir, if_halted, mem(32'h0));
    end
  endtask

  task automatic test_wrap();
    id_cond = 1'b1;
    id_npc = 32'hFFFF_FFFF;
    step();
    id_cond = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_align: addr=%h want fffffffc", imem_addr);
    end
    step();
    checks++;
    if (if_id_npc !== 32'h0 || if_id_ir !== mem(32'hFFFF_FFFC) || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc: npc=%h ir=%h addr=%h want 0 %h 0",
               if_id_npc, if_id_ir, imem_addr, mem(32'hFFFF_FFFC));
    end
  endtask

  // Program-order model: each delivered word is the next sequential
  // address after the last delivery or the last taken redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] p_ir;
    logic [31:0] p_npc;
    logic [31:0] p_target;
    bit p_hold;
    bit p_redir;
    bit p_ill;
    int deliveries;
    fixed_lat = -1;
    max_lat = 3;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_pc = 32'h0;
    p_ir = NOP;
    p_npc = 32'h0;
    p_hold = 1'b0;
    p_redir = 1'b0;
    p_ill = 1'b0;
    p_target = '0;
    deliveries = 0;
    for (int n = 0; n < 800; n++) begin
      step();
      if (p_redir) begin
        checks++;
        if (if_id_ir !== NOP || (p_ill && if_iar !== p_npc - 32'd4)) begin
          failures++;
          $display("FAIL rnd_redir@%0d: ir=%h iar=%h want 0 %h",
                   n, if_id_ir, if_iar, p_npc - 32'd4);
        end
        exp_pc = p_target;
      end else if (p_hold) begin
        checks++;
        if (if_id_ir !== p_ir || if_id_npc !== p_npc) begin
          failures++;
          $display("FAIL rnd_hold@%0d: ir=%h npc=%h want %h %h",
                   n, if_id_ir, if_id_npc, p_ir, p_npc);
        end
      end else if (if_id_ir !== p_ir || if_id_npc !== p_npc) begin
        checks++;
        deliveries++;
        if (if_id_ir !== mem(exp_pc) || if_id_npc !== exp_pc + 32'd4) begin
          failures++;
          $display("FAIL rnd_deliver@%0d: ir=%h npc=%h want %h %h",
                   n, if_id_ir, if_id_npc, mem(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
      end
      p_ir = if_id_ir;
      p_npc = if_id_npc;
      stall = ($urandom_range(0, 3) == 0);
      dc_wait = ($urandom_range(0, 5) == 0);
      id_cond = ($urandom_range(0, 9) == 0);
      id_illegal_instr = ($urandom_range(0, 29) == 0);
      id_npc = $urandom & 32'h0000_0FFF;
      p_hold = stall | dc_wait;
      p_ill = id_illegal_instr & ~p_hold;
      p_redir = (id_cond | id_illegal_instr) & ~p_hold;
      p_target = id_illegal_instr ? TRAP : (id_npc & ~32'd3);
    end
    stall = 1'b0;
    dc_wait = 1'b0;
    id_cond = 1'b0;
    id_illegal_instr = 1'b0;
    checks++;
    if (deliveries < 50) begin
      failures++;
      $display("FAIL rnd_progress: deliveries=%0d want >=50", deliveries);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_redirect();
    test_squash();
    test_stall();
    test_illegal();
    test_halt();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
